pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/riscv_pkg.sv | 13 +
 rtl/pipeline_ctrl_if.sv | 18 +
 rtl/hazard_detect.sv | 10 +
 rtl/pipeline_ctrl.sv | 78 +++++++
 tb/tb_pipeline_ctrl.sv | 111 +++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared controller state encodings and base RV32I opcode constants.
package riscv_pkg;
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01
    } state_t;
    localparam int WAIT_W = 8;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: pipeline status inputs and hazard/flush control outputs of the controller.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic ex_memread, ex_branch_taken, mem_memread, mem_memwrite, dmem_ready;
    logic pc_write, ifid_write, control_sel, ifid_flush, freeze, dmem_req, mem_timeout;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output id_rs1, id_rs2, ex_rd, ex_memread, ex_branch_taken, mem_memread, mem_memwrite, dmem_ready,
        input  pc_write, ifid_write, control_sel, ifid_flush, freeze, dmem_req, mem_timeout, state,
               stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_memread, ex_branch_taken, mem_memread, mem_memwrite, dmem_ready,
        output pc_write, ifid_write, control_sel, ifid_flush, freeze, dmem_req, mem_timeout, state,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the load in EX and the sources of the instruction in ID.
module hazard_detect (
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rd,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    output logic       o_hazard
);
    assign o_hazard = i_ex_memread & (i_ex_rd != 5'd0) & ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/freeze control for a 5-stage pipeline with a data-memory wait FSM.
// Priority is memory wait > branch flush > load-use stall; all controls are combinational.
module pipeline_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input logic         clk,
    input logic         reset,
    pipeline_ctrl_if.slave bus
);
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    state_t             r_state, w_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;
    logic               r_mem_timeout;
    logic               w_hazard, w_req, w_in_wait, w_wait, w_tmo_hit, w_flush, w_stall;
    logic               w_pc_write, w_control_sel, w_ifid_flush, w_freeze, w_dmem_req;

    hazard_detect u_hazard (
        .i_ex_memread (bus.ex_memread),
        .i_ex_rd      (bus.ex_rd),
        .i_id_rs1     (bus.id_rs1),
        .i_id_rs2     (bus.id_rs2),
        .o_hazard     (w_hazard)
    );

    assign w_req     = bus.mem_memread | bus.mem_memwrite;
    assign w_in_wait = r_state == ST_MEM_WAIT;
    // The release cycle of MEM_WAIT behaves like RUN so a held branch/hazard is acted on at once.
    assign w_wait    = ~bus.dmem_ready & (w_in_wait | ((r_state == ST_RUN) & w_req));
    assign w_tmo_hit = w_in_wait & ~bus.dmem_ready & (r_wait_cnt == TMO_LAST);
    assign w_flush   = ~w_wait & bus.ex_branch_taken;
    assign w_stall   = ~w_wait & ~bus.ex_branch_taken & w_hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_RUN;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = (w_wait && !w_tmo_hit) ? ST_MEM_WAIT : ST_RUN;
    end

    always_comb begin
        w_pc_write    = ~reset & ~w_wait & ~w_stall;
        w_control_sel = reset | w_flush | w_stall;
        w_ifid_flush  = reset | w_flush;
        w_freeze      = ~reset & w_wait;
        w_dmem_req    = ~reset & w_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_wait_cnt <= (w_in_wait && w_wait && !w_tmo_hit) ? r_wait_cnt + 1'b1 : '0;
            if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_tmo_hit) r_mem_timeout <= 1'b1;
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_pc_write;
    assign bus.control_sel = w_control_sel;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.freeze      = w_freeze;
    assign bus.dmem_req    = w_dmem_req;
    assign bus.mem_timeout = r_mem_timeout;
    assign bus.state       = r_state;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors with a queue scoreboard checked by a negedge monitor.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(16)) bus ();
    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct packed {
        logic rst; logic [4:0] rs1, rs2, rd; logic exmr, br, mr, mw, rdy;
    } in_t;
    typedef struct packed {
        logic [5:0] ctl; logic tmo; logic [1:0] st; logic [15:0] sc, fc;
    } exp_t;

    // ctl = {pc_write, ifid_write, control_sel, ifid_flush, freeze, dmem_req}
    localparam logic [5:0] NRM = 6'b110000, STL = 6'b001000, FLS = 6'b111100;
    localparam logic [5:0] WT  = 6'b000011, RST = 6'b001100, NRQ = 6'b110001, FLQ = 6'b111101;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic in_t I(logic r, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic exmr, logic br, logic mr, logic mw, logic rdy);
        return {r, rs1, rs2, rd, exmr, br, mr, mw, rdy};
    endfunction

    function automatic exp_t E(logic [5:0] c, logic t, logic [1:0] s, logic [15:0] sc, logic [15:0] fc);
        return {c, t, s, sc, fc};
    endfunction

    task automatic step(input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        reset               = i.rst;
        bus.id_rs1          = i.rs1;
        bus.id_rs2          = i.rs2;
        bus.ex_rd           = i.rd;
        bus.ex_memread      = i.exmr;
        bus.ex_branch_taken = i.br;
        bus.mem_memread     = i.mr;
        bus.mem_memwrite    = i.mw;
        bus.dmem_ready      = i.rdy;
        q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] x);
        if (a !== x) begin
            miscompares++;
            $display("FAIL vec%0d %s: got %0h expected %0h", vectors, n, a, x);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                vectors++;
                chk("ctl", 16'({bus.pc_write, bus.ifid_write, bus.control_sel, bus.ifid_flush,
                                bus.freeze, bus.dmem_req}), 16'(e.ctl));
                chk("mem_timeout", 16'(bus.mem_timeout), 16'(e.tmo));
                chk("state", 16'(bus.state), 16'(e.st));
                chk("stall_cnt", bus.stall_cnt, e.sc);
                chk("flush_cnt", bus.flush_cnt, e.fc);
            end
        end
    end

    initial begin
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.ex_rd = 0; bus.ex_memread = 0; bus.ex_branch_taken = 0;
        bus.mem_memread = 0; bus.mem_memwrite = 0; bus.dmem_ready = 0;
        step(I(1, 0, 0, 0, 0, 0, 0, 0, 0), E(RST, 0, 0, 0, 0));
        step(I(1, 0, 0, 0, 0, 0, 0, 0, 0), E(RST, 0, 0, 0, 0));
        step(I(0, 1, 2, 3, 0, 0, 0, 0, 0), E(NRM, 0, 0, 0, 0));
        step(I(0, 1, 5, 5, 1, 0, 0, 0, 0), E(STL, 0, 0, 0, 0));
        step(I(0, 1, 2, 3, 0, 0, 0, 0, 0), E(NRM, 0, 0, 1, 0));
        step(I(0, 0, 0, 0, 1, 0, 0, 0, 0), E(NRM, 0, 0, 1, 0));
        step(I(0, 7, 0, 7, 1, 0, 0, 0, 0), E(STL, 0, 0, 1, 0));
        step(I(0, 1, 5, 5, 1, 1, 0, 0, 0), E(FLS, 0, 0, 2, 0));
        step(I(0, 1, 2, 3, 0, 0, 0, 0, 0), E(NRM, 0, 0, 2, 1));
        step(I(0, 1, 5, 5, 0, 0, 0, 0, 0), E(NRM, 0, 0, 2, 1));
        step(I(0, 1, 5, 5, 1, 1, 1, 0, 0), E(WT,  0, 0, 2, 1));
        step(I(0, 1, 5, 5, 1, 1, 1, 0, 0), E(WT,  0, 1, 2, 1));
        step(I(0, 1, 5, 5, 1, 1, 1, 0, 0), E(WT,  0, 1, 2, 1));
        step(I(0, 1, 5, 5, 1, 1, 1, 0, 1), E(FLQ, 0, 1, 2, 1));
        step(I(0, 1, 2, 3, 0, 0, 0, 0, 0), E(NRM, 0, 0, 2, 2));
        step(I(0, 1, 2, 3, 0, 0, 0, 1, 1), E(NRQ, 0, 0, 2, 2));
        step(I(0, 1, 2, 3, 0, 0, 1, 0, 0), E(WT,  0, 0, 2, 2));
        for (int k = 0; k < 4; k++)
            step(I(0, 1, 2, 3, 0, 0, 1, 0, 0), E(WT, 0, 1, 2, 2));
        step(I(0, 1, 2, 3, 0, 0, 0, 0, 0), E(NRM, 1, 0, 2, 2));
        step(I(0, 1, 2, 3, 0, 0, 0, 0, 0), E(NRM, 1, 0, 2, 2));
        step(I(0, 1, 2, 3, 0, 0, 1, 0, 0), E(WT,  1, 0, 2, 2));
        step(I(0, 1, 2, 3, 0, 0, 1, 0, 0), E(WT,  1, 1, 2, 2));
        step(I(1, 1, 2, 3, 0, 0, 1, 0, 0), E(RST, 0, 0, 0, 0));
        step(I(0, 1, 2, 3, 0, 0, 0, 0, 0), E(NRM, 0, 0, 0, 0));
        step(I(0, 1, 5, 5, 1, 0, 0, 0, 0), E(STL, 0, 0, 0, 0));
        step(I(0, 1, 2, 3, 0, 0, 0, 0, 0), E(NRM, 0, 0, 1, 0));
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
